// File: rtl/adc_serial_responder.sv
// Emulates the ADC side of the four-channel serial link: decodes the 16-bit
// control word shifted in while TFS is low, and streams the selected channel's sample out while RFS is high.
module adc_serial_responder (
  input  logic       clk_clk,
  input  logic       reset_n,
  input  logic       RFS,
  input  logic       TFS,
  input  logic       SCLK,
  input  logic       SPI_OUT,
  output logic       SPI_IN,
  input  logic       wr_en,
  input  logic [1:0] wr_ch,
  input  logic [9:0] wr_data,
  output logic [1:0] cur_ch,
  output logic       frame_done,
  output logic       ctrl_err,
  output logic       frame_abort
);

  logic [9:0]  r_sample [4];
  logic [15:0] r_rxWord;
  logic [4:0]  r_rxCnt;
  logic [15:0] r_txWord;
  logic [3:0]  r_txCnt;
  logic        r_spiIn;
  logic [1:0]  r_curCh;
  logic        r_frameDone;
  logic        r_ctrlErr;
  logic        r_frameAbort;

  logic        w_shift;
  logic        w_endFrame;
  logic        w_shortFrame;
  logic        w_headerOk;
  logic        w_accept;
  logic [1:0]  w_newCh;
  logic [1:0]  w_chNext;
  logic [9:0]  w_sampleNext;
  logic        w_txActive;

  always_comb begin
    w_shift      = !TFS && SCLK;
    w_endFrame   = TFS && (r_rxCnt != 5'd0);
    w_shortFrame = r_rxCnt < 5'd12;
    w_headerOk   = r_rxWord[15:12] == 4'b0110;
    w_accept     = w_endFrame && !w_shortFrame && w_headerOk;
    // Control bits 10:9 are inverted in their upper bit relative to the channel number.
    w_newCh      = r_rxWord[10:9] ^ 2'b10;
    w_chNext     = w_accept ? w_newCh : r_curCh;
    w_sampleNext = r_sample[w_chNext];
    w_txActive   = RFS && SCLK;
  end

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_sample[i] <= 10'd0;
    end else if (wr_en) begin
      r_sample[wr_ch] <= wr_data;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxWord     <= 16'd0;
      r_rxCnt      <= 5'd0;
      r_curCh      <= 2'd0;
      r_frameDone  <= 1'b0;
      r_ctrlErr    <= 1'b0;
      r_frameAbort <= 1'b0;
    end else begin
      r_frameDone  <= 1'b0;
      r_ctrlErr    <= 1'b0;
      r_frameAbort <= 1'b0;
      if (w_shift) begin
        if (r_rxCnt < 5'd16) begin
          r_rxWord[4'd15 - r_rxCnt[3:0]] <= SPI_OUT;
          r_rxCnt <= r_rxCnt + 5'd1;
        end
      end else if (w_endFrame) begin
        r_rxCnt <= 5'd0;
        if (w_shortFrame) begin
          r_frameAbort <= 1'b1;
        end else if (!w_headerOk) begin
          r_ctrlErr <= 1'b1;
        end else begin
          r_curCh     <= w_newCh;
          r_frameDone <= 1'b1;
        end
      end
    end
  end

  // Idle edges keep reloading so the MSB is already on the line at the first RFS edge.
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_txWord <= 16'd0;
      r_txCnt  <= 4'd0;
      r_spiIn  <= 1'b0;
    end else if (!w_txActive) begin
      r_txWord <= {w_sampleNext, w_chNext, 4'b0000};
      r_spiIn  <= w_sampleNext[9];
      r_txCnt  <= 4'd0;
    end else begin
      if (r_txCnt != 4'd15) begin
        r_spiIn <= r_txWord[4'd14 - r_txCnt];
        r_txCnt <= r_txCnt + 4'd1;
      end else begin
        r_spiIn <= 1'b0;
      end
    end
  end

  assign SPI_IN      = r_spiIn;
  assign cur_ch      = r_curCh;
  assign frame_done  = r_frameDone;
  assign ctrl_err    = r_ctrlErr;
  assign frame_abort = r_frameAbort;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: drives controller-style frames on
// the negedge and captures SPI_IN as the controller would see it at each posedge.
module tb_adc_serial_responder;

  logic       clk_clk;
  logic       reset_n;
  logic       RFS;
  logic       TFS;
  logic       SCLK;
  logic       SPI_OUT;
  logic       SPI_IN;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [9:0] wr_data;
  logic [1:0] cur_ch;
  logic       frame_done;
  logic       ctrl_err;
  logic       frame_abort;

  int         checkCount;
  int         passCount;
  logic       spiSeen;
  logic [15:0] rdWord;

  adc_serial_responder dut (
    .clk_clk     (clk_clk),
    .reset_n     (reset_n),
    .RFS         (RFS),
    .TFS         (TFS),
    .SCLK        (SCLK),
    .SPI_OUT     (SPI_OUT),
    .SPI_IN      (SPI_IN),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .cur_ch      (cur_ch),
    .frame_done  (frame_done),
    .ctrl_err    (ctrl_err),
    .frame_abort (frame_abort)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // One clock: drive on the negedge, note what the controller will sample, then settle past the posedge.
  task automatic applyStimulus(input logic tfs, input logic rfs, input logic sclk, input logic sdo,
                               input logic we, input logic [1:0] wch, input logic [9:0] wdat);
    @(negedge clk_clk);
    TFS = tfs; RFS = rfs; SCLK = sclk; SPI_OUT = sdo;
    wr_en = we; wr_ch = wch; wr_data = wdat;
    #1 spiSeen = SPI_IN;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic writeSample(input logic [1:0] ch, input logic [9:0] val);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ch, val);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
  endtask

  task automatic sendControl(input logic [15:0] word, input int nbits,
                             input logic we, input logic [1:0] wch, input logic [9:0] wdat);
    for (int i = 0; i < nbits; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, word[15-i], 1'b0, 2'd0, 10'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, we, wch, wdat);
  endtask

  task automatic readFrame(input string tag, output logic [15:0] data);
    data = 16'd0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'd0);
      data[15-k] = spiSeen;
      if (k == 0) checkOutput({tag, "_pulsesLow"}, {frame_done, ctrl_err, frame_abort}, 3'b000);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'd0);
    checkOutput({tag, "_tailZero"}, spiSeen, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
  endtask

  logic [9:0]  sweepSample [4];
  logic [15:0] sweepCtrl   [4];
  logic [15:0] sweepExpect [4];

  initial begin
    checkCount = 0;
    passCount  = 0;
    sweepSample = '{10'h001, 10'h155, 10'h2AA, 10'h3FF};
    sweepCtrl   = '{16'h6480, 16'h6680, 16'h6080, 16'h6280};
    sweepExpect = '{16'h0040, 16'h5550, 16'hAAA0, 16'hFFF0};

    reset_n = 1'b0;
    TFS = 1'b1; RFS = 1'b0; SCLK = 1'b0; SPI_OUT = 1'b0;
    wr_en = 1'b0; wr_ch = 2'd0; wr_data = 10'd0;
    repeat (3) @(posedge clk_clk);
    #1;
    checkOutput("resetOutputs", {SPI_IN, cur_ch, frame_done, ctrl_err, frame_abort}, 6'd0);
    #2 reset_n = 1'b1;

    $display("[TB] channel select");
    writeSample(2'd1, 10'h2A5);
    sendControl(16'h6680, 12, 1'b0, 2'd0, 10'd0);
    checkOutput("sel_curCh", cur_ch, 2'd1);
    checkOutput("sel_pulses", {frame_done, ctrl_err, frame_abort}, 3'b100);
    readFrame("sel", rdWord);
    checkOutput("sel_word", rdWord, 16'hA950);
    readFrame("reread", rdWord);
    checkOutput("reread_word", rdWord, 16'hA950);

    $display("[TB] full sweep");
    for (int c = 0; c < 4; c++) writeSample(c[1:0], sweepSample[c]);
    for (int c = 0; c < 4; c++) begin
      sendControl(sweepCtrl[c], 12, 1'b0, 2'd0, 10'd0);
      checkOutput("sweep_curCh", cur_ch, c[1:0]);
      readFrame("sweep", rdWord);
      checkOutput("sweep_word", rdWord, sweepExpect[c]);
      checkOutput("sweep_sample", rdWord[15:6], sweepSample[c]);
    end

    $display("[TB] bad header");
    sendControl(16'h7480, 12, 1'b0, 2'd0, 10'd0);
    checkOutput("bad_pulses", {frame_done, ctrl_err, frame_abort}, 3'b010);
    checkOutput("bad_curCh", cur_ch, 2'd3);

    $display("[TB] short frame");
    sendControl(16'h6480, 8, 1'b0, 2'd0, 10'd0);
    checkOutput("short_pulses", {frame_done, ctrl_err, frame_abort}, 3'b001);
    checkOutput("short_curCh", cur_ch, 2'd3);
    sendControl(16'h6480, 12, 1'b0, 2'd0, 10'd0);
    checkOutput("afterShort_pulses", {frame_done, ctrl_err, frame_abort}, 3'b100);
    checkOutput("afterShort_curCh", cur_ch, 2'd0);
    readFrame("afterShort", rdWord);
    checkOutput("afterShort_word", rdWord, 16'h0040);

    $display("[TB] write collision");
    writeSample(2'd2, 10'h111);
    sendControl(16'h6080, 12, 1'b1, 2'd2, 10'h222);
    checkOutput("coll_curCh", cur_ch, 2'd2);
    readFrame("coll1", rdWord);
    checkOutput("coll_first", rdWord, 16'h4460);
    readFrame("coll2", rdWord);
    checkOutput("coll_second", rdWord, 16'h88A0);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 10'd0);
    checkOutput("preReset_spi", SPI_IN, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("midReset_outputs", {SPI_IN, cur_ch, frame_done, ctrl_err, frame_abort}, 6'd0);
    #2 reset_n = 1'b1;
    sendControl(16'h6280, 12, 1'b0, 2'd0, 10'd0);
    checkOutput("postReset_pulses", {frame_done, ctrl_err, frame_abort}, 3'b100);
    checkOutput("postReset_curCh", cur_ch, 2'd3);
    readFrame("postReset", rdWord);
    checkOutput("postReset_word", rdWord, 16'h0030);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/adc_serial_responder.md
# adc_serial_responder

Synthesizable emulation of the ADC end of the four-channel serial link driven by the ADC data controller. It decodes the 16-bit control word shifted in during a TFS-low frame and returns the selected channel's 10-bit sample, MSB first, during RFS-high frames. The block sits on the FPGA as a loopback and hardware-in-the-loop stand-in for the physical ADC. Samples are loaded from a local parallel write port.

## Interface
- No parameters. Widths are fixed: 10-bit samples, 16-bit serial words, 4 channels.
- clk_clk  in  1  system clock; the same clock as the controller.
- reset_n  in  1  asynchronous, active-low reset.
- RFS  in  1  receive frame sync from the controller; high means a data-out frame.
- TFS  in  1  transmit frame sync from the controller; low means a control-in frame.
- SCLK  in  1  serial clock enable from the controller.
- SPI_OUT  in  1  control bit from the controller. It changes on the negedge of clk_clk.
- SPI_IN  out  1  data bit to the controller. It is registered on the posedge of clk_clk.
- wr_en  in  1  sample register write strobe.
- wr_ch  in  2  sample register index.
- wr_data  in  10  sample value.
- cur_ch  out  2  channel currently selected for readout.
- frame_done  out  1  one-cycle pulse when a valid control word is accepted.
- ctrl_err  out  1  one-cycle pulse when a complete control word has a bad header.
- frame_abort  out  1  one-cycle pulse when a control frame ends with fewer than 12 bits.

## Operation
- **Sample registers.** There are four 10-bit sample registers, sample[0..3].
  - wr_en writes wr_data into sample[wr_ch] on the posedge.
- **Control capture.**
  - Each posedge with TFS==0 && SCLK==1 shifts SPI_OUT into rx_word[15-rx_cnt], MSB first.
  - rx_cnt is 5 bits and saturates at 16; bits beyond 16 are ignored.
- **End of control frame.** This is the first posedge with TFS==1 and rx_cnt!=0. rx_cnt clears at that edge.
  - rx_cnt<12: pulse frame_abort; channel unchanged.
  - rx_word[15:12]!=4'b0110: pulse ctrl_err; channel unchanged.
  - Otherwise: cur_ch <= rx_word[10:9] ^ 2'b10 and frame_done pulses.
  - Resulting channel mapping: word 0x6480 selects ch0, 0x6680 ch1, 0x6080 ch2, 0x6280 ch3.
  - Bits [8:0] are don't-care.
- **Readout.** ch_next is the new channel at an end-of-frame edge carrying a valid word; otherwise it is cur_ch.
  - Each posedge where !(RFS && SCLK): tx_word <= {sample[ch_next], ch_next, 4'b0000}, SPI_IN <= sample[ch_next][9], tx_cnt <= 0.
  - Each posedge with RFS && SCLK: SPI_IN <= tx_word[14-tx_cnt] and tx_cnt increments.
  - After bit 0, SPI_IN holds 0 until RFS drops.
- **Read-only frames.** An RFS frame with no TFS frame re-reads cur_ch unchanged.
- **Reset (asynchronous, any time, including mid-frame).** Every register clears:
  - samples = 0, cur_ch = 0, SPI_IN = 0, tx_word = 0, rx_word = 0, rx_cnt = 0, tx_cnt = 0.
  - frame_done = 0, ctrl_err = 0, frame_abort = 0.
  - A partial frame is discarded.

## Timing
- Controller read alignment:
  - The controller samples SPI_IN on the same posedges on which the responder advances.
  - At its k-th sampling edge it sees tx_word[15-k].
  - Bit 15 is therefore valid before the first RFS&&SCLK edge, because of the reload during idle.
- Data is pipelined by one frame: a data frame returns the channel selected by the preceding control frame.
- Standard controller frame:
  - TFS is low for 12 sampled edges, delivering bits 15..4.
  - TFS is high for one edge, which is the end-of-frame edge.
  - The new channel's MSB is on SPI_IN one edge later, when RFS is first seen high.
- frame_done, ctrl_err and frame_abort assert on the end-of-frame edge and deassert the following cycle. They are mutually exclusive.
- Write versus reload on the same edge: the reload uses the pre-write sample value. A write during an active RFS frame does not alter tx_word until the next reload.
- SPI_OUT is sampled half a cycle after the controller changes it; no resynchronization is applied.

## Test plan
- **Reset values.** Assert reset_n=0 mid-frame -> all outputs 0 immediately. The next frame starts from rx_cnt=0.
- **Channel select.** Write sample[1]=10'h2A5; send word 0x6680 (12 bits) -> cur_ch=1 and frame_done pulses once. The next RFS frame returns serial bits 1010100101 01 0000.
- **Full sweep.** Send words for ch0..ch3 in sequence with samples 0x001, 0x155, 0x2AA, 0x3FF -> the controller-side 10-bit captures equal each sample, delayed by one frame.
- **Bad header.** Send 0x7480 -> ctrl_err pulses and cur_ch is unchanged.
- **Short frame.** Raise TFS after 8 bits -> frame_abort pulses and cur_ch is unchanged. A following valid frame is accepted normally.
- **Write collision.** wr_en to the selected channel (0x111 -> 0x222) on the end-of-frame edge -> that frame returns 0x111 and the next frame returns 0x222.
